// File: rtl/regfile_dump_reader.sv
// Purpose: walks a register-file async read port from first_addr to last_addr (wrapping) and streams each word out.
// Latency: start accepted at edge N -> READ in cycle N+1 -> out_valid from cycle N+2; at most one word per 2 cycles.
// Backpressure: a captured word is held stable in HOLD until out_ready; abort cancels from any busy state.
module regfile_dump_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] cur_q,       cur_d;
    logic [ADDR_W-1:0] last_q,      last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;

    // The read port always sees the current pointer; rf_data only matters in READ.
    assign rf_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    // Next-state logic: sequence the walk, capture on READ, release on handshake.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        case (state_q)
            S_IDLE: begin
                // abort in IDLE wins over start so a simultaneous request is dropped
                if (start && !abort) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    // rf_data is sampled at the edge, so a same-edge write is not seen
                    out_data_d  = rf_data;
                    out_addr_d  = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // natural ADDR_W overflow gives the wrap from top entry to 0
                        cur_d   = cur_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything so outputs drop to 0 immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump ranges plus hand-written corner sequences.
// Expected words are queued when a dump is started and popped when the DUT hands a word over.
// Inputs are driven 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        busy;
    logic        done;

    logic        rdy_sel;
    logic        rdy_fix;
    logic        rdy_rnd;
    wire         out_ready_w = rdy_sel ? rdy_rnd : rdy_fix;

    logic [31:0] rf [32];
    logic        rf_init;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } word_t;

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         n;
        bit         rnd;
    } vec_t;

    word_t exp_q[$];
    int    total;
    int    bad;
    int    done_cnt;
    int    word_cnt;

    logic        pv, pr, prev_done;
    logic [31:0] pd;
    logic [4:0]  pa;

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .abort      (abort),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready_w),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: async read, write on the rising edge.
    assign rf_data = rf[rf_addr];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    always @(posedge clk) begin
        #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pops, hold stability and done pulse width.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready_w) begin
                word_t e;
                word_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {27'd0, out_addr}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_addr", {59'd0, out_addr}, {59'd0, e.a});
                    chk("word_data", {32'd0, out_data}, {32'd0, e.d});
                end
            end
            if (pv && !pr && out_valid) begin
                chk("hold_data", {32'd0, out_data}, {32'd0, pd});
                chk("hold_addr", {59'd0, out_addr}, {59'd0, pa});
            end
            if (done) begin
                done_cnt++;
                chk("done_single", {63'd0, prev_done}, 64'd0);
            end
        end
        pv        = out_valid;
        pr        = out_ready_w;
        pd        = out_data;
        pa        = out_addr;
        prev_done = done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
        @(posedge clk);
        #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (done_cnt != d0) ok = 1'b1;
        end
        chk("done_seen", {63'd0, ok}, 64'd1);
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int n, input bit rnd);
        int d0, w0;
        logic [4:0] a;
        for (int i = 0; i < n; i++) begin
            a = f + 5'(i);
            exp_q.push_back('{a: a, d: 32'h100 + {27'd0, a}});
        end
        d0      = done_cnt;
        w0      = word_cnt;
        rdy_sel = rnd;
        rdy_fix = 1'b1;
        pulse_start(f, l);
        wait_done(d0);
        tick();
        tick();
        chk("done_count", done_cnt - d0, 1);
        chk("word_count", word_cnt - w0, n);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_after", {63'd0, busy}, 64'd0);
        rdy_sel = 1'b0;
    endtask

    vec_t vt[6];

    initial begin
        int d0;
        bit found;
        total = 0; bad = 0; done_cnt = 0; word_cnt = 0;
        pv = 0; pr = 0; prev_done = 0; pd = 0; pa = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        first_addr = '0; last_addr = '0;
        rdy_sel = 1'b0; rdy_fix = 1'b1;
        rf_init = 1'b1; rf_we = 1'b0; rf_wa = '0; rf_wd = '0;

        vt[0] = '{f: 5'd0,  l: 5'd31, n: 32, rnd: 1'b0};
        vt[1] = '{f: 5'd30, l: 5'd1,  n: 4,  rnd: 1'b0};
        vt[2] = '{f: 5'd31, l: 5'd0,  n: 2,  rnd: 1'b0};
        vt[3] = '{f: 5'd12, l: 5'd12, n: 1,  rnd: 1'b0};
        vt[4] = '{f: 5'd5,  l: 5'd10, n: 6,  rnd: 1'b1};
        vt[5] = '{f: 5'd10, l: 5'd9,  n: 32, rnd: 1'b1};

        // reset state
        #3;
        chk("rst_outputs", {rf_addr, out_valid, out_data, out_addr, busy, done}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst     = 1'b0;
        rf_init = 1'b0;

        for (int v = 0; v < 6; v++) run_dump(vt[v].f, vt[v].l, vt[v].n, vt[v].rnd);

        // single word with backpressure: latency and hold stability
        rdy_sel = 1'b0;
        rdy_fix = 1'b0;
        exp_q.push_back('{a: 5'd7, d: 32'h107});
        d0 = done_cnt;
        pulse_start(5'd7, 5'd7);
        tick();
        chk("read_cycle", {busy, out_valid, 1'b0, rf_addr}, {1'b1, 1'b0, 1'b0, 5'd7});
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_word", {out_valid, out_addr, out_data}, {1'b1, 5'd7, 32'h107});
        end
        @(posedge clk);
        #1;
        rdy_fix = 1'b1;
        wait_done(d0);
        tick();
        chk("hold_done_cnt", done_cnt - d0, 1);
        chk("hold_queue", exp_q.size(), 0);

        // write to the address being read in the same READ cycle
        exp_q.push_back('{a: 5'd3, d: 32'h103});
        d0 = done_cnt;
        pulse_start(5'd3, 5'd3);
        rf_we = 1'b1; rf_wa = 5'd3; rf_wd = 32'hDEAD;
        @(posedge clk);
        #1;
        rf_we = 1'b0;
        wait_done(d0);
        chk("wr_queue1", exp_q.size(), 0);
        exp_q.push_back('{a: 5'd3, d: 32'hDEAD});
        d0 = done_cnt;
        pulse_start(5'd3, 5'd3);
        wait_done(d0);
        chk("wr_queue2", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rf_we = 1'b1; rf_wd = 32'h103;
        @(posedge clk);
        #1;
        rf_we = 1'b0;

        // abort during HOLD of address 5, with an ignored start on the way
        rdy_fix = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back('{a: 5'(i), d: 32'h100 + i});
        d0 = done_cnt;
        pulse_start(5'd0, 5'd31);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (out_valid && out_addr == 5'd5) begin
                found = 1'b1;
            end else if (out_valid) begin
                logic [4:0] cur_a;
                cur_a = out_addr;
                @(posedge clk);
                #1;
                rdy_fix = 1'b1;
                if (cur_a == 5'd2) begin
                    start = 1'b1; first_addr = 5'd20; last_addr = 5'd21;
                end
                @(posedge clk);
                #1;
                rdy_fix = 1'b0;
                start   = 1'b0;
            end
        end
        chk("abort_reach5", {63'd0, found}, 64'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        tick();
        chk("abort_idle", {62'd0, busy, out_valid}, 64'd0);
        for (int c = 0; c < 4; c++) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_queue", exp_q.size(), 0);

        // abort beats start in IDLE
        @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b1; first_addr = 5'd0; last_addr = 5'd0;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        tick();
        chk("abort_over_start", {63'd0, busy}, 64'd0);

        // asynchronous reset in the middle of a READ cycle
        rdy_fix = 1'b1;
        pulse_start(5'd0, 5'd31);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {rf_addr, out_valid, out_data, out_addr, busy, done}, 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        d0  = word_cnt;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_idle", {62'd0, busy, out_valid}, 64'd0);
        end
        chk("post_rst_words", word_cnt, d0);
        run_dump(5'd2, 5'd3, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width (32 entries).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a dump; sampled only in IDLE.
REQ-006 The block SHALL have port first_addr, input, ADDR_W bits: first register to read; latched on accepted start.
REQ-007 The block SHALL have port last_addr, input, ADDR_W bits: last register to read; latched on accepted start.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel the dump in progress.
REQ-009 The block SHALL have port rf_addr, output, ADDR_W bits: read address driven to the register-file asynchronous read port.
REQ-010 The block SHALL have port rf_data, input, DATA_W bits: combinational read data returned for rf_addr.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data/out_addr hold a valid word.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: captured register value.
REQ-014 The block SHALL have port out_addr, output, ADDR_W bits: index of out_data.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: single-cycle pulse after the last word is accepted.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, READ, HOLD and DONE.
REQ-018 From IDLE with start=1, the block SHALL latch first_addr into cur and last_addr into last, then enter READ.
REQ-019 In READ, rf_addr SHALL equal cur; at the clock edge the block SHALL register rf_data into out_data and cur into out_addr, set out_valid=1 and enter HOLD.
REQ-020 In HOLD, out_valid, out_data and out_addr SHALL remain stable until out_ready=1.
REQ-021 On out_valid&out_ready with cur==last, the block SHALL clear out_valid and enter DONE.
REQ-022 On out_valid&out_ready with cur!=last, the block SHALL clear out_valid, set cur=cur+1 modulo 2^ADDR_W and enter READ.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL enter IDLE.
REQ-024 Latency: start accepted at edge N gives READ in cycle N+1 and out_valid=1 from cycle N+2; throughput SHALL be at most one word per 2 cycles.
REQ-025 Address wrap: if first_addr>last_addr, reading SHALL continue 31->0 up to last_addr; word count SHALL be ((last-first) mod 32)+1.
REQ-026 If first_addr==last_addr, the block SHALL deliver exactly one word.
REQ-027 start asserted while busy=1 SHALL be ignored.
REQ-028 abort=1 in READ, HOLD or DONE SHALL force IDLE at the next edge with out_valid=0 and done=0; in IDLE, abort SHALL take priority over start.
REQ-029 A register-file write to the same address in the READ cycle SHALL NOT affect the captured value; the pre-edge value is captured.
REQ-030 rf_addr SHALL equal cur in every state, and rf_data SHALL be ignored outside READ.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force state=IDLE, cur=0, last=0, rf_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0 and done=0.
REQ-032 Reset asserted mid-dump SHALL discard the dump; after release, the block SHALL wait for a new start.

Verification
REQ-033 Register file preloaded rf[i]=0x100+i, first=0, last=31, out_ready=1 -> 32 words, addr 0..31, data 0x100..0x11F in order, one done pulse, busy low after.
REQ-034 first=30, last=1 -> exactly 4 words, addr 30,31,0,1, then done.
REQ-035 first=last=7, out_ready held 0 for 5 cycles after out_valid -> out_data=0x107 and out_addr=7 stable for all 5 cycles; one word is delivered after out_ready=1.
REQ-036 Register-file write of 0xDEAD to rf[3] in the READ cycle for address 3 -> captured word is 0x103; the next dump returns 0xDEAD.
REQ-037 abort during HOLD of address 5 (dump 0..31) -> IDLE next cycle, out_valid=0, no done pulse; start pulses during the dump are ignored.
REQ-038 rst asserted asynchronously mid-cycle during READ -> all outputs 0 immediately; no words are delivered after release until a new start.
